// File: rtl/serial_digit_adder_pkg.sv
// serial_digit_adder_pkg: shared FSM encoding and slice-count helpers
package serial_digit_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int ndig_of(input int width, input int digit);
    return width / digit;
  endfunction
  function automatic int cnt_width(input int ndig);
    return ndig > 1 ? $clog2(ndig) : 1;
  endfunction
endpackage

// File: rtl/serial_digit_adder_digit_adder.sv
// digit_adder: DIGIT-bit ripple adder from full-adder cells, exposing MSB carry-in
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cm
);
  logic [DIGIT:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign co = c[DIGIT];
  assign cm = c[DIGIT-1];
endmodule

// File: rtl/serial_digit_adder.sv
// serial_digit_adder: WIDTH-bit add/subtract, DIGIT bits per clock through one shared slice
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NDIG = ndig_of(WIDTH, DIGIT);
  localparam int CW = cnt_width(NDIG);
  state_t state, state_nx;
  logic [WIDTH-1:0] opa, opb, res;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [DIGIT-1:0] ds;
  logic [CW-1:0] cnt;
  logic carry, dco, dcm, last;
  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .x (opa[DIGIT-1:0]),
    .y (opb[DIGIT-1:0]),
    .ci(carry),
    .s (ds),
    .co(dco),
    .cm(dcm)
  );
  assign last = cnt == CW'(NDIG - 1);
  // new digit enters at the top; after NDIG shifts the result is aligned
  assign cat = {ds, res};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      opa   <= a;
      opb   <= sub ? ~b : b;
      carry <= sub ? ~cin : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      carry <= dco;
      res   <= cat[WIDTH+DIGIT-1:DIGIT];
      opa   <= opa >> DIGIT;
      opb   <= opb >> DIGIT;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= cat[WIDTH+DIGIT-1:DIGIT];
        cout <= dco;
        // equal operand MSBs with a differing result MSB == carry into MSB xor carry out
        ovf  <= dco ^ dcm;
      end
    end
endmodule
